// File: rtl/branch_ctrl.sv
// Branch resolution and PC register: redirect/target combinational, pc/flush/pulses update one edge later.
// Stall holds pc and the flush counter; a redirect overrides stall.
module branch_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             valid_ex,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] pc_ex,
  input  logic [WIDTH-1:0] imm_ex,
  input  logic [WIDTH-1:0] rs1_out,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic             cmpop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic [WIDTH-1:0] target,
  output logic             flush,
  output logic             misalign,
  output logic             illegal_br
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             flush_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             misalign_q;
  logic             illegal_q;

  logic             v;
  logic             cond;
  logic             br_sel;
  logic             taken;
  logic             misaligned;
  logic             illegal_hit;

  assign cmpop = funct3[1];
  assign v     = valid_ex & ~flush_q;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = br_eq;
      3'b001:  cond = ~br_eq;
      3'b100:  cond = br_lt;
      3'b101:  cond = ~br_lt;
      3'b110:  cond = br_lt;
      3'b111:  cond = ~br_lt;
      default: cond = 1'b0;
    endcase
  end

  // JALR wins over JAL, which wins over a conditional branch.
  assign br_sel = is_branch & ~is_jal & ~is_jalr;

  always_comb begin
    target = pc_ex + imm_ex;
    if (is_jalr) begin
      target = (rs1_out + imm_ex) & ~WIDTH'(1);
    end
  end

  // JALR already has bit0 cleared, so checking both low bits covers every type.
  assign misaligned  = |target[1:0];
  assign taken       = v & (is_jalr | is_jal | (br_sel & cond));
  assign redirect    = taken & ~misaligned;
  assign illegal_hit = v & br_sel & (funct3[2:1] == 2'b01);

  always_comb begin
    pc_d = pc_q + WIDTH'(4);
    if (redirect) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= taken & misaligned;
      illegal_q  <= illegal_hit;
      case (state_q)
        IDLE: begin
          if (redirect) begin
            state_q <= FLUSH;
            cnt_q   <= FLUSH_INIT;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (!stall) begin
            if (cnt_q == 3'd1) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              flush_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + WIDTH'(4);
  assign flush      = flush_q;
  assign misalign   = misalign_q;
  assign illegal_br = illegal_q;

endmodule
